serial_ripple_subtractor: RTL and testbench
===========================================

# serial_ripple_subtractor

Multi-cycle, chunk-serial ripple-borrow subtractor. It computes `{borrow, min - sub - borrow_in}` over `WIDTH/CHUNK` clock cycles, one `CHUNK`-bit slice per cycle. It is the subtract-direction companion to the team's combinational ripple-carry adders. It sits behind a valid/ready handshake so it can be dropped between pipelined datapath stages of the approximate-arithmetic blocks. An optional lower-part approximation mirrors the lower-part-OR adder family.

## Interface
Parameters:
- `WIDTH`, default 24: operand width. Must be a multiple of `CHUNK`.
- `CHUNK`, default 4: bits processed per cycle. `N = WIDTH/CHUNK` cycles per operation.
- `LOWER`, default 8: approximate lower-part width. Used only with the macro. Multiple of `CHUNK`, `0 <= LOWER <= WIDTH`.

Ports:
- `clk_i`, in, 1: clock. All state updates on the rising edge.
- `rst_ni`, in, 1: reset. Asynchronous, active-low.
- `valid_i`, in, 1: operands valid.
- `ready_o`, out, 1: block can accept operands.
- `min_i`, in, `WIDTH`: minuend.
- `sub_i`, in, `WIDTH`: subtrahend.
- `borrow_i`, in, 1: borrow-in, subtracted at bit 0.
- `valid_o`, out, 1: result valid.
- `ready_i`, in, 1: downstream accepts the result.
- `result_o`, out, `WIDTH+1`: `{borrow_out, diff}`. `borrow_out = 1` iff `min_i < sub_i + borrow_i`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `ready_o = 1`.
  - On `valid_i & ready_o`: latch `min_i`, `sub_i`, and `borrow_i` into the running-borrow register. Clear chunk counter. Go to RUN.
- RUN, one chunk per cycle, least significant first:
  - `diff_chunk = min_chunk - sub_chunk - borrow`, using ripple-borrow inside the chunk.
  - The chunk's borrow-out updates the running-borrow register.
  - The diff chunk is written into the result register at slice `counter`. Counter increments.
  - After the chunk with `counter = N-1`: go to DONE.
- DONE:
  - `valid_o = 1`.
  - `result_o = {running borrow, diff register}`.
  - On `ready_i`: go to IDLE.
- `ready_o` is low in RUN and DONE. `valid_i` is ignored there; operands are neither sampled nor queued.
- `result_o` holds its last value in IDLE and RUN. It changes only on the final RUN cycle.
- Arithmetic is unsigned modulo `2^WIDTH`. The borrow is the `WIDTH`-th result bit. No overflow flag.

## Timing
- Reset values: state IDLE, `ready_o = 1`, `valid_o = 0`, `result_o = 0`, counter 0, all operand registers 0.
- Latency: for acceptance at edge T0, chunks are processed at T1..TN, and `valid_o` is high from just after edge TN. With the defaults, `N = 6`.
- Earliest next acceptance: the edge after the result handshake. Peak throughput is one operation per `N+2` cycles.
- Backpressure: while `valid_o & ~ready_i`, `result_o` and `valid_o` are held stable for an unbounded time.
- Simultaneous `ready_i` and new `valid_i` in DONE: the result completes. The new operands are not accepted until IDLE the next cycle.
- Reset mid-operation (RUN or DONE):
  - Immediate return to reset values. The in-flight result is discarded; no `valid_o` pulse.
  - The first operation after release behaves as from a cold start.
- `ready_o` and `valid_o` are decoded from state registers only. There are no combinational paths from inputs.

## Configuration
- Macro: `LOWER_PART_APPROX_EN`.
- Defined:
  - Result bits `[LOWER-1:0] = min ^ sub`, with no borrow chain and `borrow_i` ignored.
  - Borrow into bit `LOWER` = `~min[LOWER-1] & sub[LOWER-1]`. If `LOWER = 0`, it is `borrow_i` and the result is exact.
  - Upper bits use exact ripple-borrow.
  - Cycle count stays `N`. Approximate chunks still take one cycle each, so the handshake is identical.
- Undefined: fully exact subtraction. `LOWER` is unused.

## Test plan
Defaults `WIDTH=24`, `CHUNK=4`, `LOWER=8`, `ready_i=1` unless stated.
- Basic: `min=0x000010`, `sub=0x000001`, `borrow_i=0` -> `result_o=25'h000000F`. `valid_o` rises exactly 6 cycles after the accept edge; `ready_o` is low meanwhile.
- Underflow: `min=0x000000`, `sub=0x000001`, `borrow_i=0` -> `result_o=25'h1FFFFFF`.
- Borrow-in: `min=sub=0x123456`, `borrow_i=1` -> `result_o=25'h1FFFFFF`.
- Backpressure: `ready_i=0` for 10 cycles after `valid_o`, with a second `valid_i` pulsed meanwhile -> result held stable and second request ignored. After `ready_i=1`, `ready_o=1` the next cycle.
- Reset in RUN: assert `rst_ni=0` for 1 cycle at RUN counter 3 -> `valid_o=0`, `ready_o=1`, `result_o=0` after release. A following operation (`0x000020 - 0x000001`) gives `25'h000001F`.
- Macro defined: `min=0x000100`, `sub=0x000001`, `borrow_i=1` -> `result_o=25'h0000101`. Undefined, with `borrow_i=0` -> `25'h00000FF`.

Source files
------------

// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: chunk-serial ripple-borrow subtractor behind a
// valid/ready handshake. Produces {borrow_out, min - sub - borrow_in} after
// WIDTH/CHUNK RUN cycles, least significant chunk first.
// Optional feature macro: LOWER_PART_APPROX_EN (lower LOWER bits computed as
// min ^ sub with no borrow chain; borrow into bit LOWER = ~min[LOWER-1] & sub[LOWER-1]).
module serial_ripple_subtractor #(
  parameter int WIDTH = 24,
  parameter int CHUNK = 4,
  parameter int LOWER = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] min_i,
  input  logic [WIDTH-1:0] sub_i,
  input  logic             borrow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH:0]   result_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Elaboration-time parameter sanity checks.
  if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of CHUNK");
  end
  if ((LOWER % CHUNK) != 0 || LOWER < 0 || LOWER > WIDTH) begin : g_bad_lower
    $error("LOWER must be a multiple of CHUNK within 0..WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] sub_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   result_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] min_chunk;
  logic [CHUNK-1:0] sub_chunk;
  logic [CHUNK-1:0] diff_chunk;
  logic             ripple_b;
  logic             chunk_borrow;
  logic [WIDTH-1:0] diff_d;
  logic             last_chunk;

  // Handshake outputs decode straight from the state register.
  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

  // Current chunk: ripple-borrow subtraction of the slice selected by the counter.
  always_comb begin
    base         = CHUNK * 32'(cnt_q);
    min_chunk    = min_q[base +: CHUNK];
    sub_chunk    = sub_q[base +: CHUNK];
    diff_chunk   = '0;
    ripple_b     = borrow_q;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      diff_chunk[i] = min_chunk[i] ^ sub_chunk[i] ^ ripple_b;
      ripple_b      = (~min_chunk[i] & sub_chunk[i]) |
                      (~(min_chunk[i] ^ sub_chunk[i]) & ripple_b);
    end
    chunk_borrow = ripple_b;
`ifdef LOWER_PART_APPROX_EN
    // Every lower chunk reports the top-bit borrow guess; only the last
    // lower chunk's value survives into the first exact chunk.
    if (base < 32'(LOWER)) begin
      diff_chunk   = min_chunk ^ sub_chunk;
      chunk_borrow = ~min_chunk[CHUNK-1] & sub_chunk[CHUNK-1];
    end
`endif
    diff_d             = diff_q;
    diff_d[base +: CHUNK] = diff_chunk;
    last_chunk         = (cnt_q == CW'(N - 1));
  end

  // Control FSM plus operand, running-borrow, diff and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      min_q    <= '0;
      sub_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            min_q    <= min_i;
            sub_q    <= sub_i;
            borrow_q <= borrow_i;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          diff_q   <= diff_d;
          borrow_q <= chunk_borrow;
          cnt_q    <= cnt_q + 1'b1;
          if (last_chunk) begin
            result_q <= {chunk_borrow, diff_d};
            cnt_q    <= '0;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor: directed cases, randomized
// operations against an arithmetic reference model, backpressure and reset.
module tb_serial_ripple_subtractor;

  localparam int W = 24;
  localparam int C = 4;
  localparam int L = 8;
  localparam int N = W / C;

  logic         clk;
  logic         rst_n;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] min_i;
  logic [W-1:0] sub_i;
  logic         borrow_i;
  logic         valid_o;
  logic         ready_i;
  logic [W:0]   result_o;

  int checks   = 0;
  int failures = 0;

  serial_ripple_subtractor #(
    .WIDTH(W),
    .CHUNK(C),
    .LOWER(L)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .min_i   (min_i),
    .sub_i   (sub_i),
    .borrow_i(borrow_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .result_o(result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction of the exact part, XOR for the approximate part.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic bi);
    int          lw;
    logic [63:0] ua, ub, t, lo, mask, r;
    logic        bl, bw;
`ifdef LOWER_PART_APPROX_EN
    lw = L;
`else
    lw = 0;
`endif
    if (lw == 0) begin
      bl = bi;
      lo = 64'd0;
    end else begin
      bl = ~a[lw-1] & b[lw-1];
      lo = 64'(a ^ b) & ((64'd1 << lw) - 64'd1);
    end
    ua   = 64'(a) >> lw;
    ub   = 64'(b) >> lw;
    bw   = (ua < ub + 64'(bl));
    t    = ua - ub - 64'(bl);
    mask = (64'd1 << (W - lw)) - 64'd1;
    r    = (64'(bw) << W) | ((t & mask) << lw) | lo;
    return r[W:0];
  endfunction

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    min_i    = a;
    sub_i    = b;
    borrow_i = bi;
    valid_i  = 1'b1;
    @(posedge clk); #1;
    valid_i  = 1'b0;
    min_i    = W'($urandom);
    sub_i    = W'($urandom);
    borrow_i = 1'($urandom);
  endtask

  // Wait for valid_o with a bound; ready_o must stay low throughout RUN.
  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    while (valid_o !== 1'b1 && lat < 3 * N) begin
      check({tag, "_ready_low"}, (W + 1)'(ready_o), '0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, (W + 1)'(lat), (W + 1)'(N));
  endtask

  // Full operation: accept, check latency and result, hold for d cycles, complete.
  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic bi, input int d, input logic [W:0] exp, input bit poke);
    ready_i = (d == 0);
    start(a, b, bi);
    wait_result(tag);
    check({tag, "_result"}, result_o, exp);
    for (int i = 0; i < d; i++) begin
      if (poke && i == 3) begin
        valid_i = 1'b1;
        min_i   = ~a;
        sub_i   = a;
      end
      @(posedge clk); #1;
      valid_i = 1'b0;
      check({tag, "_hold_valid"}, (W + 1)'(valid_o), (W + 1)'(1));
      check({tag, "_hold_ready"}, (W + 1)'(ready_o), '0);
      check({tag, "_hold_result"}, result_o, exp);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    check({tag, "_idle_ready"}, (W + 1)'(ready_o), (W + 1)'(1));
    check({tag, "_idle_valid"}, (W + 1)'(valid_o), '0);
    check({tag, "_idle_result"}, result_o, exp);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         bi;
    logic [W:0]   exp;

    rst_n    = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    min_i    = '0;
    sub_i    = '0;
    borrow_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", (W + 1)'(ready_o), (W + 1)'(1));
    check("rst_valid", (W + 1)'(valid_o), '0);
    check("rst_result", result_o, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic cases
`ifndef LOWER_PART_APPROX_EN
    op("basic",     24'h000010, 24'h000001, 1'b0, 0, 25'h000000F, 1'b0);
    op("underflow", 24'h000000, 24'h000001, 1'b0, 0, 25'h1FFFFFF, 1'b0);
    op("borrowin",  24'h123456, 24'h123456, 1'b1, 0, 25'h1FFFFFF, 1'b0);
    op("lowcase",   24'h000100, 24'h000001, 1'b0, 0, 25'h00000FF, 1'b0);
    op("maxmin",    24'hFFFFFF, 24'h000000, 1'b1, 0, 25'h0FFFFFE, 1'b0);
`else
    op("approx",    24'h000100, 24'h000001, 1'b1, 0, 25'h0000101, 1'b0);
    op("approx_b",  24'h000000, 24'h000080, 1'b0, 0, 25'h1FFFF80, 1'b0);
`endif

    // Backpressure with an ignored second request
    op("bp", 24'h00ABCD, 24'h001234, 1'b0, 10, model(24'h00ABCD, 24'h001234, 1'b0), 1'b1);

    // Simultaneous ready_i and valid_i in DONE: new operands wait for IDLE
    ready_i = 1'b0;
    start(24'h555555, 24'h0AAAAA, 1'b1);
    wait_result("simul");
    check("simul_result", result_o, model(24'h555555, 24'h0AAAAA, 1'b1));
    a = 24'h000300;
    b = 24'h000400;
    ready_i  = 1'b1;
    valid_i  = 1'b1;
    min_i    = a;
    sub_i    = b;
    borrow_i = 1'b0;
    @(posedge clk); #1;
    check("simul_not_accepted", (W + 1)'(ready_o), (W + 1)'(1));
    check("simul_valid_drop", (W + 1)'(valid_o), '0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("simul_accepted", (W + 1)'(ready_o), '0);
    wait_result("simul2");
    check("simul2_result", result_o, model(a, b, 1'b0));
    @(posedge clk); #1;
    check("simul2_idle", (W + 1)'(ready_o), (W + 1)'(1));

    // Reset during RUN at counter 3
    ready_i = 1'b1;
    start(24'h123456, 24'h000111, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("rrun_ready", (W + 1)'(ready_o), (W + 1)'(1));
    check("rrun_valid", (W + 1)'(valid_o), '0);
    check("rrun_result", result_o, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rrun_rel_ready", (W + 1)'(ready_o), (W + 1)'(1));
    check("rrun_rel_valid", (W + 1)'(valid_o), '0);
    check("rrun_rel_result", result_o, '0);
`ifndef LOWER_PART_APPROX_EN
    op("after_rst", 24'h000020, 24'h000001, 1'b0, 0, 25'h000001F, 1'b0);
`else
    op("after_rst", 24'h000020, 24'h000001, 1'b0, 0, model(24'h000020, 24'h000001, 1'b0), 1'b0);
`endif

    // Randomized operations against the reference model
    for (int k = 0; k < 24; k++) begin
      a  = W'($urandom);
      b  = (k % 5 == 0) ? a : W'($urandom);
      bi = 1'($urandom_range(0, 1));
      if (k % 7 == 3) begin
        a = '1;
        b = '1;
      end
      exp = model(a, b, bi);
      op("rand", a, b, bi, $urandom_range(0, 3), exp, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
